// File: rtl/iter_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : iter_div_unit
//  Description : Iterative restoring radix-2 integer divider. It accepts one
//                signed or unsigned request at a time and returns the
//                quotient and remainder a fixed WIDTH+1 cycles after accept.
//                The tag travels alongside the operation unchanged.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            : single clock, all state changes on its rising edge
//    reset          : synchronous, active-high reset
//    in_valid       : request valid
//    in_ready       : unit accepts a request this cycle
//    in_signed      : 1 = signed divide, 0 = unsigned divide
//    in_dividend    : dividend (WIDTH bits)
//    in_divisor     : divisor  (WIDTH bits)
//    in_tag         : opaque tag, returned with the result
//    flush          : cancel any in-flight operation and drop its result
//    out_valid      : result valid
//    out_ready      : consumer takes the result
//    out_quotient   : quotient  (WIDTH bits)
//    out_remainder  : remainder (WIDTH bits)
//    out_tag        : tag of the request that produced the result
//    busy           : an operation is in flight or waiting to be consumed
// ============================================================================
module iter_div_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The counter runs 0..WIDTH: WIDTH shift/subtract steps, then one cycle
  // where the sign fixup is applied and the result is published.
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quo;      // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] r_rem;      // partial remainder, always < divisor when divisor != 0
  logic [WIDTH-1:0] r_dvs;      // divisor magnitude
  logic             r_neg_q;    // quotient must be negated
  logic             r_neg_r;    // remainder takes the (negative) dividend sign
  logic             r_dz;       // divide by zero
  logic [TAG_W-1:0] r_tag;
  logic [WIDTH-1:0] r_out_q;
  logic [WIDTH-1:0] r_out_r;
  logic [TAG_W-1:0] r_out_tag;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_idle;
  logic w_calc;
  logic w_done;
  logic w_accept;

  assign w_idle   = (r_state == S_IDLE);
  assign w_calc   = (r_state == S_CALC);
  assign w_done   = (r_state == S_DONE);

  // Flush blocks acceptance so a flushed cycle never starts a new operation.
  assign in_ready = ~flush & (w_idle | (w_done & out_ready));
  assign w_accept = in_valid & in_ready;

  assign out_valid     = w_done;
  assign busy          = w_calc | w_done;
  assign out_quotient  = r_out_q;
  assign out_remainder = r_out_r;
  assign out_tag       = r_out_tag;

  // --------------------------------------------------------------------------
  // Operand conditioning at accept
  // --------------------------------------------------------------------------
  // Magnitudes are formed in WIDTH+1 bits so the most negative value has an
  // exact positive magnitude; that magnitude still fits WIDTH unsigned bits.
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH:0]   w_dvd_ext;
  logic [WIDTH:0]   w_dvs_ext;
  logic [WIDTH:0]   w_dvd_abs;
  logic [WIDTH:0]   w_dvs_abs;
  logic             w_dvs_zero;

  assign w_dvd_neg  = in_signed & in_dividend[WIDTH-1];
  assign w_dvs_neg  = in_signed & in_divisor[WIDTH-1];
  assign w_dvd_ext  = {w_dvd_neg, in_dividend};
  assign w_dvs_ext  = {w_dvs_neg, in_divisor};
  assign w_dvd_abs  = w_dvd_neg ? -w_dvd_ext : w_dvd_ext;
  assign w_dvs_abs  = w_dvs_neg ? -w_dvs_ext : w_dvs_ext;
  assign w_dvs_zero = (in_divisor == '0);

  // --------------------------------------------------------------------------
  // One restoring step
  // --------------------------------------------------------------------------
  // Because the partial remainder is below the divisor, the shifted value is
  // below twice the divisor; a successful subtraction therefore leaves the
  // top bit clear, and a borrow always sets it.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_fits     = ~w_diff[WIDTH];
  assign w_rem_next = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};

  // --------------------------------------------------------------------------
  // Sign fixup
  // --------------------------------------------------------------------------
  // With a zero divisor every trial subtraction succeeds, so the remainder
  // register ends up holding |dividend|; re-applying the dividend sign then
  // returns the original dividend. Only the quotient needs overriding.
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_quo_fix = r_dz    ? '1 : (r_neg_q ? -r_quo : r_quo);
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

  // --------------------------------------------------------------------------
  // Sequential
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
      r_tag     <= '0;
      r_out_q   <= '0;
      r_out_r   <= '0;
      r_out_tag <= '0;
    end else if (flush) begin
      // Any pending result is discarded, even if a handshake coincides.
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (w_accept) begin
      // Accept is only possible from IDLE or from DONE while the result is
      // being taken, so loading here covers back-to-back operation too.
      r_state <= S_CALC;
      r_cnt   <= '0;
      r_quo   <= w_dvd_abs[WIDTH-1:0];
      r_rem   <= '0;
      r_dvs   <= w_dvs_abs[WIDTH-1:0];
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
      r_dz    <= w_dvs_zero;
      r_tag   <= in_tag;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_IDLE;
        end
        S_CALC: begin
          if (r_cnt == C_CNT_LAST) begin
            r_out_q   <= w_quo_fix;
            r_out_r   <= w_rem_fix;
            r_out_tag <= r_tag;
            r_state   <= S_DONE;
          end else begin
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iter_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iter_div_unit
//  Description : Self-checking bench for iter_div_unit (WIDTH=32, TAG_W=5).
//                The stimulus side pushes expected results into a queue; a
//                monitor on the falling edge compares whatever the divider
//                presents against the head of that queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_div_unit;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  iter_div_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_signed     (in_signed),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .in_tag        (in_tag),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_tag       (out_tag),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [TAG_W-1:0] tag;
    longint           acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  bit   seen   = 1'b0;
  bit   last_acc;
  bit   use_dir = 1'b0;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] dir_r;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: plain integer division in 64-bit arithmetic, truncating
  // toward zero, with the divide-by-zero convention applied first.
  function automatic exp_t model(input logic s, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
    exp_t   e;
    longint x;
    longint y;
    e.tag = t;
    e.acc = 0;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
    end else begin
      if (s) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
      end else begin
        x = longint'({32'd0, a});
        y = longint'({32'd0, b});
      end
      e.q = 32'(x / y);
      e.r = 32'(x % y);
    end
    return e;
  endfunction

  // One clock: decide acceptance mid-cycle, then after the edge record the
  // expected response for an accepted request.
  task automatic tick();
    bit   acc;
    exp_t e;
    @(negedge clk);
    acc = in_valid && in_ready && !reset;
    @(posedge clk);
    #1;
    last_acc = acc;
    if (acc) begin
      e = model(in_signed, in_dividend, in_divisor, in_tag);
      if (use_dir) begin
        e.q = dir_q;
        e.r = dir_r;
      end
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [TAG_W-1:0] t);
    in_signed   = s;
    in_dividend = a;
    in_divisor  = b;
    in_tag      = t;
    in_valid    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic dsend(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] q,
                       input logic [WIDTH-1:0] r);
    use_dir = 1'b1;
    dir_q   = q;
    dir_r   = r;
    send(s, a, b, t);
    use_dir = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    chk("drain_timeout", sb.size(), 0);
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: checks first, then retires / discards queue entries.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", busy, sb.size() != 0);
      chk("in_ready", in_ready, !flush && (sb.size() == 0 || (out_valid && out_ready)));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", out_valid, 0);
        end else begin
          chk("quotient", out_quotient, sb[0].q);
          chk("remainder", out_remainder, sb[0].r);
          chk("tag", out_tag, sb[0].tag);
          if (!seen) begin
            seen = 1'b1;
            chk("latency", cyc - sb[0].acc, WIDTH + 1);
          end
        end
      end
      if (reset || flush) begin
        sb.delete();
        seen = 1'b0;
      end else if (out_valid && out_ready && sb.size() != 0) begin
        void'(sb.pop_front());
        seen = 1'b0;
      end
    end
  end

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_signed   = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    in_tag      = '0;
    flush       = 1'b0;
    out_ready   = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_quotient", out_quotient, 0);
    chk("rst_remainder", out_remainder, 0);
    chk("rst_tag", out_tag, 0);
    mon_en = 1'b1;

    // Basic and sign / boundary cases
    dsend(1'b0, 32'd100, 32'd7, 5'd3, 32'd14, 32'd2);
    drain();
    dsend(1'b1, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    drain();
    dsend(1'b1, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'hFFFF_FFFD, 32'd1);
    drain();
    dsend(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 32'd0);
    drain();
    dsend(1'b0, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 32'd5);
    drain();
    dsend(1'b1, 32'hFFFF_FFF6, 32'd0, 5'd8, 32'hFFFF_FFFF, 32'hFFFF_FFF6);
    drain();
    dsend(1'b0, 32'hFFFF_FFFF, 32'd1, 5'd9, 32'hFFFF_FFFF, 32'd0);
    drain();

    // Flush during the tenth CALC cycle, then a fresh request right after
    send(1'b0, 32'd1000, 32'd3, 5'd10);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dsend(1'b0, 32'd9, 32'd4, 5'd11, 32'd2, 32'd1);
    drain();

    // Consumer stall in DONE, then handshake and accept in the same cycle
    out_ready = 1'b0;
    dsend(1'b0, 32'd50, 32'd5, 5'd12, 32'd10, 32'd0);
    for (int i = 0; i < 60 && !out_valid; i++) tick();
    chk("stall_valid", out_valid, 1);
    repeat (5) begin
      tick();
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready   = 1'b1;
    use_dir     = 1'b1;
    dir_q       = 32'd11;
    dir_r       = 32'd0;
    in_signed   = 1'b0;
    in_dividend = 32'd77;
    in_divisor  = 32'd7;
    in_tag      = 5'd13;
    in_valid    = 1'b1;
    tick();
    chk("same_cycle_accept", last_acc, 1);
    in_valid = 1'b0;
    use_dir  = 1'b0;
    drain();

    // Reset in the middle of a calculation
    send(1'b1, 32'hFFFF_0000, 32'd3, 5'd14);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_quotient", out_quotient, 0);
    chk("midrst_remainder", out_remainder, 0);
    chk("midrst_tag", out_tag, 0);

    // Random traffic with back-pressure, flushes and input churn
    for (int n = 0; n < 60000; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 99) == 0);
      in_signed   = 1'($urandom_range(0, 1));
      in_dividend = pick();
      in_divisor  = pick();
      in_tag      = 5'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
